// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle sequencer.
// Steps fetch/decode/execute/mem/writeback and drives datapath selects.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [1:0]           result_src,
  output logic [3:0]           alu_control,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [3:0] S_BOOT     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  logic [3:0]           state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 f3_ok;
  logic                 retire;
  logic [3:0]           alu_fn;

  assign f3_ok = (funct3 == 3'b000) ||
                 (funct3 == 3'b110) ||
                 (funct3 == 3'b111);

  always_comb begin
    alu_fn = ALU_ADD;
    unique case (funct3)
      3'b000: begin
        if (op == OP_R && funct7b5)
          alu_fn = ALU_SUB;
        else
          alu_fn = ALU_ADD;
      end
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):
            state_d = S_MEMADR;
          (op == OP_R):
            state_d = f3_ok ? S_EXECR : S_TRAP;
          (op == OP_I):
            state_d = f3_ok ? S_EXECI : S_TRAP;
          (op == OP_BR):
            state_d = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
          default:
            state_d = S_TRAP;
        endcase
      end
      S_MEMADR:
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)
          state_d = S_MEMWB;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)
          state_d = S_FETCH;
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_BOOT;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    trap        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        if (op == OP_SW)
          imm_src = 2'b01;
        else if (op == OP_BR)
          imm_src = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_fn;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_fn;
      end
      S_ALUWB:
        reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
      end
      S_TRAP:
        trap = 1'b1;
      default: ;
    endcase
  end

  // a store retires in the cycle memory accepts it
  assign retire = (state_q == S_MEMWB) ||
                  (state_q == S_ALUWB) ||
                  (state_q == S_BEQ) ||
                  (state_q == S_MEMWRITE && mem_ready);

  assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
  assign instret   = instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle scoreboard of expected control vectors.
// Driver pushes expectations, negedge monitor pops and compares.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, adr_src, ir_write;
  logic        pc_write, reg_write, trap;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [3:0]  alu_control;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ir = '0;

  typedef struct {
    string       tag;
    logic [18:0] ctl;
    logic [31:0] ir;
  } exp_t;
  exp_t sb[$];

  logic [18:0] obs;

  multicycle_control #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .alu_control(alu_control),
    .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write,
                reg_write, alu_src_a, alu_src_b, imm_src,
                result_src, alu_control, trap};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_ctl"}, 32'(obs), 32'(e.ctl));
      chk({e.tag, "_instret"}, instret, e.ir);
    end
  end

  function automatic logic [18:0] v(
    input logic req, wr, adr, irw, pcw, rw,
    input logic [1:0] a, b, imm, res,
    input logic [3:0] alu, input logic tr);
    return {req, wr, adr, irw, pcw, rw, a, b, imm, res, alu, tr};
  endfunction

  task automatic step(input string tag, input logic rdy,
                      input logic z, input logic [18:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero = z;
    e.tag = tag;
    e.ctl = ctl;
    e.ir = exp_ir;
    sb.push_back(e);
  endtask

  function automatic logic rz();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fetch(input int waits);
    repeat (waits)
      step("fetch_wait", 1'b0, rz(),
           v(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,4'h0,0));
    step("fetch", 1'b1, rz(),
         v(1,0,0,1,1,0,2'b00,2'b10,2'b00,2'b10,4'h0,0));
  endtask

  task automatic decode(input logic [1:0] imm);
    step("decode", 1'b1, rz(),
         v(0,0,0,0,0,0,2'b01,2'b01,imm,2'b00,4'h0,0));
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  task automatic do_lw(input int fw, input int mw);
    set_ir(7'b0000011, 3'b010, 1'b0);
    fetch(fw);
    decode(2'b00);
    step("memadr", 1'b1, rz(),
         v(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,4'h0,0));
    repeat (mw)
      step("memread_wait", 1'b0, rz(),
           v(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0));
    step("memread", 1'b1, rz(),
         v(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0));
    step("memwb", 1'b1, rz(),
         v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,4'h0,0));
    exp_ir++;
  endtask

  task automatic do_sw_head(input int fw);
    set_ir(7'b0100011, 3'b010, 1'b0);
    fetch(fw);
    decode(2'b01);
    step("memadr_sw", 1'b1, rz(),
         v(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,4'h0,0));
  endtask

  task automatic do_sw(input int mw);
    do_sw_head(0);
    repeat (mw)
      step("memwrite_wait", 1'b0, rz(),
           v(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0));
    step("memwrite", 1'b1, rz(),
         v(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0));
    exp_ir++;
  endtask

  task automatic do_alu(input logic itype, input logic [2:0] f3,
                        input logic f7, input logic [3:0] alu);
    set_ir(itype ? 7'b0010011 : 7'b0110011, f3, f7);
    fetch(0);
    decode(2'b00);
    step(itype ? "execi" : "execr", 1'b1, rz(),
         v(0,0,0,0,0,0,2'b10,itype ? 2'b01 : 2'b00,
           2'b00,2'b00,alu,0));
    step("aluwb", 1'b1, rz(),
         v(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,4'h0,0));
    exp_ir++;
  endtask

  task automatic do_beq(input logic z);
    set_ir(7'b1100011, 3'b000, 1'b0);
    fetch(0);
    decode(2'b10);
    step(z ? "beq_taken" : "beq_not", 1'b1, z,
         v(0,0,0,0,z,0,2'b10,2'b00,2'b00,2'b00,4'h1,0));
    exp_ir++;
  endtask

  task automatic do_trap(input logic [6:0] o, input logic [2:0] f3);
    set_ir(o, f3, 1'b0);
    fetch(0);
    decode(o == 7'b0100011 ? 2'b01 :
           o == 7'b1100011 ? 2'b10 : 2'b00);
    repeat (10)
      step("trap", rz(), rz(),
           v(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,1));
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_async_ctl"}, 32'(obs), 32'h0);
    chk({tag, "_async_instret"}, instret, 32'h0);
    exp_ir = '0;
    step({tag, "_held"}, 1'b1, 1'b0, 19'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      exp_t e;
      e.tag = {tag, "_release"};
      e.ctl = 19'h0;
      e.ir = exp_ir;
      sb.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step("reset", 1'b1, 1'b1, 19'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      exp_t e;
      e.tag = "boot";
      e.ctl = 19'h0;
      e.ir = exp_ir;
      sb.push_back(e);
    end

    do_lw(2, 1);
    do_alu(1'b0, 3'b000, 1'b1, 4'h1);
    do_alu(1'b0, 3'b111, 1'b0, 4'h2);
    do_alu(1'b0, 3'b110, 1'b0, 4'h3);
    do_alu(1'b0, 3'b000, 1'b0, 4'h0);
    do_alu(1'b1, 3'b000, 1'b1, 4'h0);
    do_alu(1'b1, 3'b111, 1'b0, 4'h2);
    do_alu(1'b1, 3'b110, 1'b1, 4'h3);
    do_beq(1'b1);
    do_beq(1'b0);
    do_sw(0);
    do_sw(2);
    do_lw(0, 0);

    do_trap(7'b1111111, 3'b000);
    async_reset("trap1");
    do_trap(7'b0110011, 3'b001);
    async_reset("trap2");

    do_alu(1'b0, 3'b000, 1'b0, 4'h0);
    do_sw_head(1);
    step("memwrite_wait", 1'b0, 1'b0,
         v(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,4'h0,0));
    async_reset("sw_reset");
    do_beq(1'b1);
    do_lw(0, 2);
    fetch(0);

    @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I core: sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath muxes, register-file write, memory handshake and the ALU's `alu_control` code. It is the producer of the ALU operation encoding. It sits between the instruction register and unified memory port on one side and the ALU, register file and PC register on the other. It supports lw, sw, add/sub/and/or, addi/andi/ori and beq; anything else traps.

## Interface
- `INSTRET_W`, 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: opcode from the instruction register.
- `funct3` in 3: instruction bits 14:12.
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request valid.
- `mem_write` out 1: request is a store.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALU-out register.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC from the result bus.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: 00 = I, 01 = S, 10 = B.
- `result_src` out 2: 00 = ALU-out register, 01 = memory data register, 10 = live ALU result.
- `alu_control` out 4: 0000 = ADD, 0001 = SUB, 0010 = AND, 0011 = OR.
- `trap` out 1: sticky illegal-instruction flag.
- `instret` out `INSTRET_W`: count of retired instructions.

## Operation
- Moore FSM. Outputs decode from state; `ir_write` and `pc_write` also qualify on `mem_ready` or `zero`. Any output not listed for a state is 0.
- States and their actions:
  - BOOT: entered on reset; all outputs 0; goes to FETCH next cycle.
  - FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10, `ir_write`=`pc_write`=`mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE on `mem_ready`.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, ADD (branch target into the ALU-out register). `imm_src` set from `op`: 0100011 gives S, 1100011 gives B, else I. Next state by `op`:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECUTER.
    - 0010011: EXECUTEI.
    - 1100011 with `funct3`=000: BEQ.
    - Any other opcode, or `funct3` not in {000, 110, 111} for R/I-types: TRAP.
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, ADD. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: `mem_req`=1, `adr_src`=1. Waits for `mem_ready`, then MEMWB.
  - MEMWB: `result_src`=01, `reg_write`=1. Goes to FETCH.
  - MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Waits for `mem_ready`, then FETCH.
  - EXECUTER: `alu_src_a`=10, `alu_src_b`=00. Goes to ALUWB.
  - EXECUTEI: `alu_src_a`=10, `alu_src_b`=01. Goes to ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1. Goes to FETCH.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00, `pc_write`=`zero`. Goes to FETCH.
  - TRAP: `trap`=1, all other outputs 0. Absorbing; only reset leaves it.
- ALU function decode, used in EXECUTER and EXECUTEI:
  - `funct3` 000: ADD, except SUB when R-type with `funct7b5`=1. `funct7b5` is ignored for I-type.
  - `funct3` 111: AND.
  - `funct3` 110: OR.
- `instret` increments by 1 on leaving MEMWB, BEQ or ALUWB, and on MEMWRITE with `mem_ready`. It wraps modulo 2^`INSTRET_W`.

## Timing
- Reset asserted: state=BOOT, `instret`=0, `trap`=0; every output is 0 asynchronously.
- Reset removed: the first request (FETCH) appears one cycle after the first rising edge.
- Latency in cycles from FETCH entry, with zero-wait memory:
  - lw: 5.
  - sw: 4.
  - R-type and I-type: 4.
  - beq: 3.
- Each cycle `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. `mem_req`, address select and `mem_write` hold stable until `mem_ready`.
- `mem_ready` outside a requesting state is ignored.
- `op`, `funct3` and `funct7b5` are sampled as they stand from DECODE onward; they are stable because `ir_write` is 0 after FETCH.
- Reset mid-operation, including during a memory wait: `mem_req` drops immediately, and no write or PC update occurs after the reset edge.
- `instret` at its all-ones value increments to 0.

## Test plan
- Reset: hold `rst_n`=0 three cycles → all outputs 0; one cycle after release, `mem_req`=1 with `adr_src`=0.
- lw (op 0000011), `mem_ready` low for 2 cycles in FETCH and 1 in MEMREAD → 8 cycles FETCH to FETCH; `reg_write`=1 only in MEMWB with `result_src`=01; `instret` goes 0→1.
- R-type sub (op 0110011, funct3 000, `funct7b5`=1) → `alu_control`=0001 in EXECUTER; and (funct3 111) → 0010; addi (op 0010011, `funct7b5`=1) → 0000.
- beq: once with `zero`=1, once with `zero`=0 → `pc_write` in BEQ is 1 and 0 respectively; both take 3 cycles; `instret` +1 each.
- Illegal: op 1111111, then funct3 001 on op 0110011 → TRAP after DECODE; `trap`=1 is held for 10 cycles with no `mem_req`; reset clears it.
- Reset in MEMWRITE with `mem_ready`=0 → `mem_write`/`mem_req` drop without a clock edge; `instret` reads 0; normal fetch resumes.
